pc_sequencer: RTL

Program-counter sequencer for the pipelined ARM core; replaces the bare stall/branch/increment logic around the instruction ROM.
- Owns the PC register and a small FSM covering reset entry, normal fetch, post-branch flush and halt.
- Applies the hazard unit's stall, the EX-stage branch redirect and an external halt/resume with fixed priority.
- Presents `pc` directly to the ROM address and drives `flush` to squash the IF/ID latch.

---
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter sequencer for the pipelined core's instruction fetch.
// It owns the PC register and a four-state FSM: reset entry, normal fetch,
// post-branch flush and halt. It applies the hazard unit's stall, the EX-stage
// branch redirect and an external halt/resume with fixed priority. `pc` feeds
// the ROM address directly, and `flush` squashes the IF/ID latch.
//
// Optional feature macro: PC_SEQ_PERF_EN
//   defined   -> saturating 16-bit stall and branch performance counters
//   undefined -> counter logic is not built; stall_cnt/branch_cnt read as 0
//
// Parameters:
//   PC_WIDTH      width of the PC and the branch target
//   RESET_VECTOR  PC value loaded on reset
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   asynchronous, active-low reset
//   stall_enable  in   hazard unit PC hold (1 = hold PC)
//   branch_taken  in   EX-stage branch decision
//   branch_pc     in   branch target, valid with branch_taken
//   halt_req      in   request to stop fetching
//   resume        in   leave HALT
//   pc            out  current fetch address (registered)
//   fetch_valid   out  ROM output at pc is a real instruction
//   flush         out  squash IF/ID contents this cycle
//   state         out  FSM state (debug)
//   stall_cnt     out  stall cycles counted
//   branch_cnt    out  branches accepted
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                stall_enable,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_pc,
    input  logic                halt_req,
    input  logic                resume,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_valid,
    output logic                flush,
    output logic [1:0]          state,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         branch_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_e;

    localparam logic [PC_WIDTH-1:0] PC_ONE = PC_WIDTH'(1);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_VECTOR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                // A stall also drops a simultaneous branch; the hazard unit
                // keeps the branch asserted until the stall clears.
                if (stall_enable) begin
                    pc_d = pc_q;
                end else if (branch_taken) begin
                    pc_d    = branch_pc;
                    state_d = FLUSH;
                end else if (halt_req) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end
            FLUSH: begin
                // branch_taken/halt_req here come from the squashed
                // instruction and are deliberately ignored.
                if (!stall_enable) begin
                    pc_d    = pc_q + PC_ONE;
                    state_d = RUN;
                end
            end
            HALT: begin
                // PC is kept so the instruction at pc is fetched first.
                if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pc          = pc_q;
    assign state       = state_q;
    assign flush       = (state_q == FLUSH);
    assign fetch_valid = (state_q == RUN) || (state_q == FLUSH);

`ifdef PC_SEQ_PERF_EN
    logic        stall_event, branch_event;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] branch_cnt_q, branch_cnt_d;

    assign stall_event  = stall_enable && ((state_q == RUN) || (state_q == FLUSH));
    assign branch_event = (state_q == RUN) && branch_taken && !stall_enable;

    // Counters saturate rather than wrap so a long run never reads as small.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        branch_cnt_d = branch_cnt_q;
        if (stall_event && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (branch_event && (branch_cnt_q != 16'hFFFF)) begin
            branch_cnt_d = branch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= 16'd0;
            branch_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            branch_cnt_q <= branch_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign branch_cnt = branch_cnt_q;
`else
    assign stall_cnt  = 16'd0;
    assign branch_cnt = 16'd0;
`endif

endmodule
